// File: rtl/calc_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : calc_key_decoder
// Function : Keypad-driven 4-digit BCD add/subtract calculator front end with
//            sequential double-dabble conversion of the result for display.
// Revision : 1.0
// ============================================================================
module calc_key_decoder #(
    parameter logic [3:0] KEY_ADD = 4'hA,
    parameter logic [3:0] KEY_SUB = 4'hB,
    parameter logic [3:0] KEY_CE  = 4'hC,
    parameter logic [3:0] KEY_AC  = 4'hD,
    parameter logic [3:0] KEY_EQ  = 4'hE,
    parameter logic [3:0] KEY_BS  = 4'hF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        key_flag,
    input  logic        key_state,
    input  logic [3:0]  key_out,
    output logic [15:0] disp_data,
    output logic        disp_neg,
    output logic        err,
    output logic        busy,
    output logic        op_pending
);

    typedef enum logic [2:0] {
        ST_ENTRY_A = 3'd0,
        ST_OP_WAIT = 3'd1,
        ST_ENTRY_B = 3'd2,
        ST_CONV    = 3'd3,
        ST_SHOW    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] entry_q, entry_d, opa_q, opa_d, disp_q, disp_d, bcd_q, bcd_d;
    logic [13:0] bin_q, bin_d;
    logic [3:0]  iter_q, iter_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        sub_q, sub_d, neg_q, neg_d, rneg_q, rneg_d;
    logic        err_q, err_d, busy_q, busy_d, pend_q, pend_d;

    function automatic logic [14:0] bcd2bin(input logic [15:0] b);
        return 15'(b[15:12]) * 15'd1000 + 15'(b[11:8]) * 15'd100 +
               15'(b[7:4]) * 15'd10 + 15'(b[3:0]);
    endfunction

    function automatic logic [15:0] dd_adj(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    logic        w_press, w_digit, w_oper, w_can_push, w_a_ge_b, w_res_neg, w_clear;
    logic [15:0] w_push, w_first, w_b_bcd;
    logic [2:0]  w_first_cnt;
    logic [14:0] w_a_bin, w_b_bin, w_res;
    logic [29:0] w_dd;

    assign w_press     = key_flag & ~key_state;
    assign w_digit     = (key_out <= 4'd9);
    assign w_oper      = (key_out == KEY_ADD) || (key_out == KEY_SUB);
    assign w_push      = {entry_q[11:0], key_out};
    assign w_can_push  = (cnt_q < 3'd4) && !((key_out == 4'd0) && (cnt_q == 3'd0));
    // A fresh entry starting with 0 stays empty so leading zeros never count.
    assign w_first     = (key_out == 4'd0) ? 16'h0000 : {12'h000, key_out};
    assign w_first_cnt = (key_out == 4'd0) ? 3'd0 : 3'd1;

    // Operand B is only live in ENTRY_B; "=" straight after an operator uses 0.
    assign w_b_bcd   = (state_q == ST_ENTRY_B) ? entry_q : 16'h0000;
    assign w_a_bin   = bcd2bin(opa_q);
    assign w_b_bin   = bcd2bin(w_b_bcd);
    assign w_a_ge_b  = (w_a_bin >= w_b_bin);
    assign w_res_neg = sub_q & ~w_a_ge_b;
    assign w_res     = !sub_q   ? (w_a_bin + w_b_bin) :
                       w_a_ge_b ? (w_a_bin - w_b_bin) : (w_b_bin - w_a_bin);

    assign w_dd = {dd_adj(bcd_q), bin_q} << 1;

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        sub_d   = sub_q;
        disp_d  = disp_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        err_d   = err_q;
        busy_d  = busy_q;
        pend_d  = pend_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        iter_d  = iter_q;
        w_clear = w_press && (key_out == KEY_AC);

        if (!w_clear) begin
            case (state_q)
                ST_ENTRY_A, ST_ENTRY_B: begin
                    if (w_press) begin
                        if (w_digit) begin
                            if (w_can_push) begin
                                entry_d = w_push;
                                cnt_d   = cnt_q + 3'd1;
                                disp_d  = w_push;
                            end
                        end else if (key_out == KEY_BS) begin
                            if (cnt_q != 3'd0) begin
                                entry_d = entry_q >> 4;
                                cnt_d   = cnt_q - 3'd1;
                                disp_d  = entry_q >> 4;
                            end
                        end else if (key_out == KEY_CE) begin
                            entry_d = 16'h0000;
                            cnt_d   = 3'd0;
                            disp_d  = 16'h0000;
                        end else if (w_oper) begin
                            if (state_q == ST_ENTRY_A) begin
                                opa_d   = entry_q;
                                sub_d   = (key_out == KEY_SUB);
                                pend_d  = 1'b1;
                                state_d = ST_OP_WAIT;
                            end
                        end else if ((key_out == KEY_EQ) && (state_q == ST_ENTRY_B)) begin
                            state_d = ST_CONV;
                        end
                    end
                end
                ST_OP_WAIT: begin
                    if (w_press) begin
                        if (w_digit) begin
                            entry_d = w_first;
                            cnt_d   = w_first_cnt;
                            disp_d  = w_first;
                            state_d = ST_ENTRY_B;
                        end else if (w_oper) begin
                            sub_d = (key_out == KEY_SUB);
                        end else if (key_out == KEY_CE) begin
                            entry_d = 16'h0000;
                            cnt_d   = 3'd0;
                            disp_d  = 16'h0000;
                        end else if (key_out == KEY_EQ) begin
                            state_d = ST_CONV;
                        end
                    end
                end
                ST_CONV: begin
                    bcd_d  = w_dd[29:14];
                    bin_d  = w_dd[13:0];
                    iter_d = iter_q + 4'd1;
                    if (iter_q == 4'd13) begin
                        disp_d  = w_dd[29:14];
                        neg_d   = rneg_q;
                        busy_d  = 1'b0;
                        pend_d  = 1'b0;
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (w_press) begin
                        if (w_digit) begin
                            entry_d = w_first;
                            cnt_d   = w_first_cnt;
                            disp_d  = w_first;
                            neg_d   = 1'b0;
                            state_d = ST_ENTRY_A;
                        end else if (w_oper && !neg_q) begin
                            opa_d   = disp_q;
                            sub_d   = (key_out == KEY_SUB);
                            pend_d  = 1'b1;
                            state_d = ST_OP_WAIT;
                        end else if (key_out == KEY_CE) begin
                            w_clear = 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // "=" evaluation is shared by ENTRY_B and OP_WAIT.
            if (state_d == ST_CONV && state_q != ST_CONV) begin
                if (w_res > 15'd9999) begin
                    state_d = ST_ERR;
                    disp_d  = 16'hEEEE;
                    err_d   = 1'b1;
                    pend_d  = 1'b0;
                end else begin
                    busy_d = 1'b1;
                    bin_d  = w_res[13:0];
                    bcd_d  = 16'h0000;
                    iter_d = 4'd0;
                    rneg_d = w_res_neg;
                end
            end
        end

        if (w_clear) begin
            state_d = ST_ENTRY_A;
            entry_d = 16'h0000;
            cnt_d   = 3'd0;
            opa_d   = 16'h0000;
            sub_d   = 1'b0;
            disp_d  = 16'h0000;
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            err_d   = 1'b0;
            busy_d  = 1'b0;
            pend_d  = 1'b0;
            bcd_d   = 16'h0000;
            bin_d   = 14'h0000;
            iter_d  = 4'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_ENTRY_A;
            entry_q <= 16'h0000;
            cnt_q   <= 3'd0;
            opa_q   <= 16'h0000;
            sub_q   <= 1'b0;
            disp_q  <= 16'h0000;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
            bcd_q   <= 16'h0000;
            bin_q   <= 14'h0000;
            iter_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            sub_q   <= sub_d;
            disp_q  <= disp_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            iter_q  <= iter_d;
        end
    end

    assign disp_data  = disp_q;
    assign disp_neg   = neg_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign op_pending = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_key_decoder
// Function : Directed self-checking bench for calc_key_decoder.
// Revision : 1.0
// ============================================================================
module tb_calc_key_decoder;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        key_flag = 1'b0;
    logic        key_state = 1'b1;
    logic [3:0]  key_out = 4'h0;
    logic [15:0] disp_data;
    logic        disp_neg, err, busy, op_pending;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    calc_key_decoder dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .key_flag   (key_flag),
        .key_state  (key_state),
        .key_out    (key_out),
        .disp_data  (disp_data),
        .disp_neg   (disp_neg),
        .err        (err),
        .busy       (busy),
        .op_pending (op_pending)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that sampled the event.
    task automatic press(input logic [3:0] k);
        key_flag  = 1'b1;
        key_state = 1'b0;
        key_out   = k;
        @(posedge Clk); #1;
        key_flag  = 1'b0;
        key_state = 1'b1;
    endtask

    task automatic press_seq(input logic [3:0] ks[$]);
        foreach (ks[i]) press(ks[i]);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            @(posedge Clk); #1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        check("rst_disp", disp_data, 16'h0000);
        check("rst_neg",  disp_neg, 0);
        check("rst_err",  err, 0);
        check("rst_busy", busy, 0);
        check("rst_pend", op_pending, 0);

        // Entry rules: leading zero, 5th digit, backspace, clear entry
        press_seq('{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5});
        check("entry_1234", disp_data, 16'h1234);
        press(4'hF);
        check("bs_0123", disp_data, 16'h0123);
        press(4'hC);
        check("ce_0000", disp_data, 16'h0000);

        // 123 + 45 with exact conversion latency
        press_seq('{4'h1, 4'h2, 4'h3, 4'hA});
        check("add_pend", op_pending, 1);
        press_seq('{4'h4, 4'h5});
        check("opb_45", disp_data, 16'h0045);
        press(4'hE);
        check("busy_n1", busy, 1);
        wait_idle(cyc);
        check("busy_cycles", cyc, 14);
        check("add_res", disp_data, 16'h0168);
        check("add_neg", disp_neg, 0);
        check("add_err", err, 0);
        check("add_pend_clr", op_pending, 0);

        // 5 - 12 = -7, then "+" ignored, digit starts new entry
        press(4'hD);
        press_seq('{4'h5, 4'hB, 4'h1, 4'h2, 4'hE});
        wait_idle(cyc);
        check("sub_res", disp_data, 16'h0007);
        check("sub_neg", disp_neg, 1);
        press(4'hA);
        check("neg_op_pend", op_pending, 0);
        check("neg_op_disp", disp_data, 16'h0007);
        press(4'h3);
        check("show_digit", disp_data, 16'h0003);
        check("show_digit_neg", disp_neg, 0);

        // Operator replace in OP_WAIT: 8 + then - 3 = 5
        press(4'hD);
        press_seq('{4'h8, 4'hA, 4'hB, 4'h3, 4'hE});
        wait_idle(cyc);
        check("op_replace", disp_data, 16'h0005);
        check("op_replace_neg", disp_neg, 0);

        // "=" straight after operator uses B = 0; then chain the result: 7 + 0 = 7, 7 + 5 = 12
        press(4'hD);
        press_seq('{4'h7, 4'hA, 4'hE});
        wait_idle(cyc);
        check("b_zero", disp_data, 16'h0007);
        press_seq('{4'hA, 4'h5, 4'hE});
        wait_idle(cyc);
        check("chain", disp_data, 16'h0012);

        // Overflow 9999 + 1
        press(4'hD);
        press_seq('{4'h9, 4'h9, 4'h9, 4'h9, 4'hA, 4'h1, 4'hE});
        check("ovf_disp", disp_data, 16'hEEEE);
        check("ovf_err", err, 1);
        check("ovf_pend", op_pending, 0);
        press(4'h5);
        check("err_digit", disp_data, 16'hEEEE);
        press(4'hC);
        check("err_ce", err, 1);
        press(4'hD);
        check("err_ac_disp", disp_data, 16'h0000);
        check("err_ac_err", err, 0);

        // Digit during conversion is dropped
        press_seq('{4'h2, 4'hA, 4'h3, 4'hE});
        press(4'h7);
        wait_idle(cyc);
        check("conv_drop_cyc", cyc, 13);
        check("conv_drop_res", disp_data, 16'h0005);

        // AC aborts a conversion
        press(4'hD);
        press_seq('{4'h2, 4'hA, 4'h3, 4'hE});
        press(4'hD);
        check("abort_busy", busy, 0);
        check("abort_disp", disp_data, 16'h0000);
        check("abort_pend", op_pending, 0);
        press(4'h4);
        check("abort_entry", disp_data, 16'h0004);

        // Release events ignored, then synchronous reset mid-entry
        press(4'hD);
        press_seq('{4'h4, 4'hA, 4'h4, 4'h2});
        check("pre_rst_disp", disp_data, 16'h0042);
        check("pre_rst_pend", op_pending, 1);
        key_flag = 1'b1; key_state = 1'b1; key_out = 4'h5;
        @(posedge Clk); #1;
        key_flag = 1'b0;
        check("release_ign", disp_data, 16'h0042);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        check("rst2_disp", disp_data, 16'h0000);
        check("rst2_pend", op_pending, 0);
        check("rst2_busy", busy, 0);
        check("rst2_err", err, 0);
        check("rst2_neg", disp_neg, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
